// File: rtl/gray2bin_track.sv
// Gray-to-binary decoder with step tracking: decodes a valid-strobed Gray stream
// and flags each accepted sample as hold, +1, -1 or an illegal step.
module gray2bin_track #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             G_valid,
    input  logic [WIDTH-1:0] G,
    output logic             B_valid,
    output logic [WIDTH-1:0] B,
    output logic             dir_up,
    output logic             dir_down,
    output logic             step_err,
    output logic [7:0]       err_count
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] g_q;
    logic             g_vld_q;
    logic [WIDTH-1:0] dec_c;
    logic [WIDTH-1:0] b_q;
    logic             b_vld_q;
    logic [WIDTH-1:0] prev_b;
    logic             have_prev;
    logic [WIDTH-1:0] delta_c;

    // Stage 1: capture the raw Gray sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            g_q     <= '0;
            g_vld_q <= 1'b0;
        end else begin
            g_vld_q <= G_valid;
            if (G_valid) begin
                g_q <= G;
            end
        end
    end

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        dec_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            dec_c[i] = ^(g_q >> i);
        end
    end

    // Stage 2: register the decoded value.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_q     <= '0;
            b_vld_q <= 1'b0;
        end else begin
            b_vld_q <= g_vld_q;
            if (g_vld_q) begin
                b_q <= dec_c;
            end
        end
    end

    assign delta_c = WIDTH'(b_q - prev_b);

    // Output stage: classify the step and resynchronise tracking on every sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            B_valid   <= 1'b0;
            B         <= '0;
            dir_up    <= 1'b0;
            dir_down  <= 1'b0;
            step_err  <= 1'b0;
            err_count <= '0;
            prev_b    <= '0;
            have_prev <= 1'b0;
        end else begin
            B_valid  <= b_vld_q;
            dir_up   <= 1'b0;
            dir_down <= 1'b0;
            step_err <= 1'b0;
            if (b_vld_q) begin
                B         <= b_q;
                prev_b    <= b_q;
                have_prev <= 1'b1;
                if (have_prev) begin
                    if (delta_c == WIDTH'(1)) begin
                        dir_up <= 1'b1;
                    end else if (delta_c == {WIDTH{1'b1}}) begin
                        dir_down <= 1'b1;
                    end else if (delta_c != '0) begin
                        step_err <= 1'b1;
                        if (err_count != CNT_MAX) begin
                            err_count <= err_count + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gray2bin_track.sv
// Bench for gray2bin_track: arithmetic reference model checked every cycle,
// plus directed sequences whose captured strobes are checked against literals.
module tb_gray2bin_track;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         reset;
    logic         G_valid;
    logic [W-1:0] G;
    logic         B_valid;
    logic [W-1:0] B;
    logic         dir_up;
    logic         dir_down;
    logic         step_err;
    logic [7:0]   err_count;

    int tests;
    int fails;

    gray2bin_track #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .G_valid   (G_valid),
        .G         (G),
        .B_valid   (B_valid),
        .B         (B),
        .dir_up    (dir_up),
        .dir_down  (dir_down),
        .step_err  (step_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       up;
        logic       dn;
        logic       err;
        logic [7:0] cnt;
    } strobe_t;

    strobe_t got[$];

    function automatic int gray_to_bin(input int g);
        int r;
        int x;
        r = g;
        x = g;
        while (x != 0) begin
            x = x >> 1;
            r = r ^ x;
        end
        return r;
    endfunction

    // Reference model: samples reach the outputs two edges after acceptance.
    int m_v0, m_v1, m_g0, m_g1;
    int m_have, m_prev, m_cnt;
    int e_valid, e_b, e_up, e_dn, e_err;

    always @(posedge clk) begin
        int b;
        int d;
        if (reset) begin
            m_v0 = 0; m_v1 = 0; m_g0 = 0; m_g1 = 0;
            m_have = 0; m_prev = 0; m_cnt = 0;
            e_valid = 0; e_b = 0; e_up = 0; e_dn = 0; e_err = 0;
        end else begin
            e_valid = m_v1; e_up = 0; e_dn = 0; e_err = 0;
            if (m_v1 != 0) begin
                b = gray_to_bin(m_g1);
                if (m_have != 0) begin
                    d = (b - m_prev + (MASK + 1)) % (MASK + 1);
                    if (d == 1) e_up = 1;
                    else if (d == MASK) e_dn = 1;
                    else if (d != 0) begin
                        e_err = 1;
                        if (m_cnt < 255) m_cnt = m_cnt + 1;
                    end
                end
                m_prev = b;
                m_have = 1;
                e_b    = b;
            end
            m_v1 = m_v0; m_g1 = m_g0;
            m_v0 = int'(G_valid); m_g0 = int'(G);
        end
    end

    // Every-cycle compare plus strobe capture for the directed checks.
    always @(posedge clk) begin
        #1;
        tests++;
        if (int'(B_valid) != e_valid || int'(B) != e_b || int'(dir_up) != e_up ||
            int'(dir_down) != e_dn || int'(step_err) != e_err || int'(err_count) != m_cnt) begin
            fails++;
            $display("FAIL model_cycle t=%0t got v=%0d B=%02h up=%0d dn=%0d err=%0d cnt=%0d want v=%0d B=%02h up=%0d dn=%0d err=%0d cnt=%0d",
                     $time, B_valid, B, dir_up, dir_down, step_err, err_count,
                     e_valid, e_b, e_up, e_dn, e_err, m_cnt);
        end
        if (B_valid) got.push_back({B, dir_up, dir_down, step_err, err_count});
    end

    task automatic check_strobe(input string name, input int idx, input int b,
                                input int up, input int dn, input int err, input int cnt);
        strobe_t s;
        tests++;
        if (idx >= got.size()) begin
            fails++;
            $display("FAIL %s strobe %0d missing (only %0d strobes)", name, idx, got.size());
        end else begin
            s = got[idx];
            if (int'(s.b) != b || int'(s.up) != up || int'(s.dn) != dn ||
                int'(s.err) != err || int'(s.cnt) != cnt) begin
                fails++;
                $display("FAIL %s strobe %0d got B=%02h up=%0d dn=%0d err=%0d cnt=%0d want B=%02h up=%0d dn=%0d err=%0d cnt=%0d",
                         name, idx, s.b, s.up, s.dn, s.err, s.cnt, b, up, dn, err, cnt);
            end
        end
    endtask

    task automatic check_count(input string name, input int want);
        tests++;
        if (got.size() != want) begin
            fails++;
            $display("FAIL %s strobe count got %0d want %0d", name, got.size(), want);
        end
    endtask

    task automatic send(input logic [W-1:0] g);
        @(negedge clk);
        G_valid = 1'b1;
        G       = g;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            G_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        G_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        got.delete();
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        G_valid = 1'b0;
        G       = '0;
        do_reset();

        tests++;
        if (B_valid !== 1'b0 || B !== 8'h00 || err_count !== 8'h00 ||
            dir_up !== 1'b0 || dir_down !== 1'b0 || step_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got v=%0b B=%02h cnt=%0d up=%0b dn=%0b err=%0b want all zero",
                     B_valid, B, err_count, dir_up, dir_down, step_err);
        end

        // Single sample: Gray 0x05 decodes to 0x06.
        send(8'h05);
        idle(5);
        check_count("single", 1);
        check_strobe("single", 0, 8'h06, 0, 0, 0, 0);

        // Full up-count sweep through all 256 codes.
        do_reset();
        for (int i = 0; i < 256; i++) send(W'(i ^ (i >> 1)));
        idle(5);
        check_count("sweep", 256);
        check_strobe("sweep_first", 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 256; i++) check_strobe("sweep", i, i, 1, 0, 0, 0);

        // Wrap in both directions.
        do_reset();
        send(8'h80);
        send(8'h00);
        idle(5);
        check_count("wrap_up", 2);
        check_strobe("wrap_up", 0, 8'hFF, 0, 0, 0, 0);
        check_strobe("wrap_up", 1, 8'h00, 1, 0, 0, 0);

        do_reset();
        send(8'h00);
        send(8'h80);
        idle(5);
        check_strobe("wrap_down", 0, 8'h00, 0, 0, 0, 0);
        check_strobe("wrap_down", 1, 8'hFF, 0, 1, 0, 0);

        // Hold then an illegal step.
        do_reset();
        send(8'h00);
        send(8'h00);
        send(8'h03);
        idle(5);
        check_count("hold_err", 3);
        check_strobe("hold_err", 0, 8'h00, 0, 0, 0, 0);
        check_strobe("hold_err", 1, 8'h00, 0, 0, 0, 0);
        check_strobe("hold_err", 2, 8'h02, 0, 0, 1, 1);

        // Gaps between samples are ignored by the step tracking.
        do_reset();
        send(8'h01);
        idle(3);
        send(8'h03);
        idle(5);
        check_count("gap", 2);
        check_strobe("gap", 0, 8'h01, 0, 0, 0, 0);
        check_strobe("gap", 1, 8'h02, 1, 0, 0, 0);
        tests++;
        if (B_valid !== 1'b0 || B !== 8'h02) begin
            fails++;
            $display("FAIL gap_hold got v=%0b B=%02h want v=0 B=02", B_valid, B);
        end

        // Reset one cycle after a sample discards it.
        do_reset();
        send(8'h07);
        @(negedge clk);
        reset   = 1'b1;
        G_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_count("midreset_drop", 0);
        send(8'h0C);
        idle(5);
        check_count("midreset_next", 1);
        check_strobe("midreset_next", 0, 8'h08, 0, 0, 0, 0);

        // 300 forced errors: binary alternates 0x80 / 0x00.
        for (int i = 0; i < 300; i++) send((i % 2 == 0) ? 8'hC0 : 8'h00);
        idle(5);
        check_count("saturate", 301);
        check_strobe("saturate", 1,   8'h80, 0, 0, 1, 1);
        check_strobe("saturate", 254, 8'h00, 0, 0, 1, 254);
        check_strobe("saturate", 255, 8'h80, 0, 0, 1, 255);
        check_strobe("saturate", 300, 8'h00, 0, 0, 1, 255);
        tests++;
        if (err_count !== 8'd255) begin
            fails++;
            $display("FAIL sat_hold got cnt=%0d want 255", err_count);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
